// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Contents: requester count, index width, hold counter width, FSM state
// encoding and the index-to-one-hot decode used to drive the grant vector.
package arb_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] id_decode(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker (purely combinational).
// Ports:
//   req [7:0] : request vector, bit i is requester i
//   ptr [2:0] : highest-priority index for this pick
//   any       : at least one request is set
//   idx [2:0] : first set request scanning ptr, ptr+1, ... modulo 8
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W-1:0] cand;

    // Scan from ptr upward; the 3-bit add wraps 7 -> 0 on its own.
    always_comb begin
        any  = 1'b0;
        idx  = ptr;
        cand = ptr;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr + ID_W'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with a bounded hold time.
// Parameter:
//   MAX_HOLD  : grant cycles before a forced release (2..255)
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-high reset
//   req [7:0] : request vector
//   done      : current grantee releases the resource
//   gnt [7:0] : one-hot grant, zero when no grant is active
//   gnt_id    : index of the current (or last) grantee
//   gnt_valid : a grant is active
//   timeout   : one-cycle pulse when the hold limit alone forced the release
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [N_REQ-1:0]   gnt_q;
    logic               gnt_valid_q;
    logic               timeout_q;

    logic               pick_any_c;
    logic [ID_W-1:0]    pick_idx_c;
    logic               req_drop_c;
    logic               hold_hit_c;
    logic               release_c;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any_c),
        .idx (pick_idx_c)
    );

    // Release conditions; only the grantee's own request bit matters during GRANT.
    assign req_drop_c = !req[gnt_id_q];
    assign hold_hit_c = (hold_q == HOLD_LAST);
    assign release_c  = done || req_drop_c || hold_hit_c;

    // Arbiter FSM with registered grant outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_id_q    <= '0;
            hold_q      <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any_c) begin
                        state_q     <= GRANT;
                        gnt_id_q    <= pick_idx_c;
                        gnt_q       <= id_decode(pick_idx_c);
                        gnt_valid_q <= 1'b1;
                        hold_q      <= '0;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= gnt_id_q + ID_W'(1);
                        // Flag only releases forced purely by the hold limit.
                        timeout_q   <= hold_hit_c && !done && !req_drop_c;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
